// File: rtl/vga_pkg.sv
// Shared raster timing constants and coordinate type for the 640x480@60 VGA path.
// Imported by the timing generator and the downstream pixel generator.
package vga_pkg;

   localparam int unsigned COORD_W = 10;
   typedef logic [COORD_W-1:0] coord_t;

   localparam int unsigned VGA_H_ACTIVE = 640;
   localparam int unsigned VGA_H_FRONT  = 16;
   localparam int unsigned VGA_H_SYNC   = 96;
   localparam int unsigned VGA_H_BACK   = 48;
   localparam int unsigned VGA_V_ACTIVE = 480;
   localparam int unsigned VGA_V_FRONT  = 10;
   localparam int unsigned VGA_V_SYNC   = 2;
   localparam int unsigned VGA_V_BACK   = 33;

   localparam int unsigned H_TOTAL = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
   localparam int unsigned V_TOTAL = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

endpackage

// File: rtl/vga_timing_generator.sv
// Raster counters plus registered sync/active/strobe decode; every output describes
// the pixel held in the counters on the previous cycle, so all outputs stay aligned.
module vga_timing_generator
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE  = VGA_H_ACTIVE,
   parameter int unsigned H_FRONT   = VGA_H_FRONT,
   parameter int unsigned H_SYNC    = VGA_H_SYNC,
   parameter int unsigned H_BACK    = VGA_H_BACK,
   parameter int unsigned V_ACTIVE  = VGA_V_ACTIVE,
   parameter int unsigned V_FRONT   = VGA_V_FRONT,
   parameter int unsigned V_SYNC    = VGA_V_SYNC,
   parameter int unsigned V_BACK    = VGA_V_BACK,
   parameter logic        HSYNC_POL = 1'b0,
   parameter logic        VSYNC_POL = 1'b0
) (
   input  logic   clk_in,
   input  logic   reset_n,
   output logic   hsync,
   output logic   vsync,
   output logic   video_active,
   output coord_t pixel_x,
   output coord_t pixel_y,
   output logic   line_start,
   output logic   frame_start
);

   localparam int unsigned H_PERIOD = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_PERIOD = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam coord_t H_LAST = COORD_W'(H_PERIOD - 1);
   localparam coord_t V_LAST = COORD_W'(V_PERIOD - 1);
   localparam coord_t H_VIS  = COORD_W'(H_ACTIVE);
   localparam coord_t V_VIS  = COORD_W'(V_ACTIVE);
   localparam coord_t HS_BEG = COORD_W'(H_ACTIVE + H_FRONT);
   localparam coord_t HS_END = COORD_W'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam coord_t VS_BEG = COORD_W'(V_ACTIVE + V_FRONT);
   localparam coord_t VS_END = COORD_W'(V_ACTIVE + V_FRONT + V_SYNC);

   coord_t r_h_cnt;
   coord_t r_v_cnt;
   coord_t w_h_next;
   coord_t w_v_next;
   logic   w_h_wrap;
   logic   w_v_wrap;

   logic   r_hsync;
   logic   r_vsync;
   logic   r_video_active;
   coord_t r_pixel_x;
   coord_t r_pixel_y;
   logic   r_line_start;
   logic   r_frame_start;

   logic   w_hs_win;
   logic   w_vs_win;
   logic   w_active;
   logic   w_x_zero;
   logic   w_y_zero;

   // >= rather than == so any out-of-range count falls back to 0 on the next step
   assign w_h_wrap = (r_h_cnt >= H_LAST);
   assign w_v_wrap = (r_v_cnt >= V_LAST);

   always_comb begin
      w_h_next = r_h_cnt + coord_t'(1);
      w_v_next = r_v_cnt;
      if (w_h_wrap) begin
         w_h_next = '0;
         w_v_next = w_v_wrap ? '0 : (r_v_cnt + coord_t'(1));
      end
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else begin
         r_h_cnt <= w_h_next;
         r_v_cnt <= w_v_next;
      end
   end

   // Decode the pre-increment position; registered below for one cycle of latency
   assign w_hs_win = (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
   assign w_vs_win = (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);
   assign w_active = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
   assign w_x_zero = (r_h_cnt == '0);
   assign w_y_zero = (r_v_cnt == '0);

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         r_hsync        <= ~HSYNC_POL;
         r_vsync        <= ~VSYNC_POL;
         r_video_active <= 1'b0;
         r_pixel_x      <= '0;
         r_pixel_y      <= '0;
         r_line_start   <= 1'b0;
         r_frame_start  <= 1'b0;
      end else begin
         r_hsync        <= w_hs_win ? HSYNC_POL : ~HSYNC_POL;
         r_vsync        <= w_vs_win ? VSYNC_POL : ~VSYNC_POL;
         r_video_active <= w_active;
         r_pixel_x      <= r_h_cnt;
         r_pixel_y      <= r_v_cnt;
         r_line_start   <= w_x_zero;
         r_frame_start  <= w_x_zero && w_y_zero;
      end
   end

   assign hsync        = r_hsync;
   assign vsync        = r_vsync;
   assign video_active = r_video_active;
   assign pixel_x      = r_pixel_x;
   assign pixel_y      = r_pixel_y;
   assign line_start   = r_line_start;
   assign frame_start  = r_frame_start;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: a default 640x480 instance and a shrunken
// high-polarity instance, checked against a cycle-count raster model.
module tb_vga_timing_generator;
   import vga_pkg::*;

   // shrunken raster: 32 x 20 = 640 cycles per frame
   localparam int S_HA = 16, S_HF = 4, S_HS = 6, S_HB = 6;
   localparam int S_VA = 12, S_VF = 2, S_VS = 2, S_VB = 4;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       va;
      logic [9:0] x;
      logic [9:0] y;
      logic       ls;
      logic       fs;
   } obs_t;

   typedef struct {
      int   n;
      obs_t exp;
   } vec_t;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;

   logic   d_hs, d_vs, d_va, d_ls, d_fs;
   coord_t d_x, d_y;
   logic   s_hs, s_vs, s_va, s_ls, s_fs;
   coord_t s_x, s_y;

   int     n_cmp = 0;
   int     n_bad = 0;
   int     n = 0;

   obs_t   q_d[$];
   obs_t   q_s[$];
   vec_t   tbl[14];
   int     tbl_idx = 0;

   int     va_cnt = 0, hs_cnt = 0, vs_cnt = 0;
   int     last_ls = -1, last_fs = -1, first_vs = -1;
   bit     track = 1'b1;

   always #20 clk = ~clk;

   vga_timing_generator u_dut (
      .clk_in(clk), .reset_n(rst_n),
      .hsync(d_hs), .vsync(d_vs), .video_active(d_va),
      .pixel_x(d_x), .pixel_y(d_y),
      .line_start(d_ls), .frame_start(d_fs)
   );

   vga_timing_generator #(
      .H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
      .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
   ) u_small (
      .clk_in(clk), .reset_n(rst_n),
      .hsync(s_hs), .vsync(s_vs), .video_active(s_va),
      .pixel_x(s_x), .pixel_y(s_y),
      .line_start(s_ls), .frame_start(s_fs)
   );

   function automatic obs_t model(int c, int ha, int hf, int hs, int hb,
                                  int va, int vf, int vs, int vb, logic hp, logic vp);
      obs_t m;
      int   ht = ha + hf + hs + hb;
      int   vt = va + vf + vs + vb;
      int   x  = c % ht;
      int   y  = (c / ht) % vt;
      m.x  = 10'(x);
      m.y  = 10'(y);
      m.hs = (x >= ha + hf && x < ha + hf + hs) ? hp : ~hp;
      m.vs = (y >= va + vf && y < va + vf + vs) ? vp : ~vp;
      m.va = (x < ha) && (y < va);
      m.ls = (x == 0);
      m.fs = (x == 0) && (y == 0);
      return m;
   endfunction

   function automatic obs_t mk(logic hs, logic vs, logic va, int x, int y, logic ls, logic fs);
      obs_t m;
      m.hs = hs; m.vs = vs; m.va = va; m.x = 10'(x); m.y = 10'(y); m.ls = ls; m.fs = fs;
      return m;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s (n=%0d): got %0h expected %0h", name, n, act, exp);
      end
   endtask

   function automatic obs_t d_obs();
      return {d_hs, d_vs, d_va, d_x, d_y, d_ls, d_fs};
   endfunction

   function automatic obs_t s_obs();
      return {s_hs, s_vs, s_va, s_x, s_y, s_ls, s_fs};
   endfunction

   task automatic check_reset(input string tag);
      check({tag, "_dflt"},  32'(d_obs()), 32'(mk(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0)));
      check({tag, "_small"}, 32'(s_obs()), 32'(mk(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0)));
   endtask

   // One pixel: queue expectations, clock, then compare both instances after the edge
   task automatic step();
      obs_t ed, es;
      q_d.push_back(model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
      q_s.push_back(model(n, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b1, 1'b1));
      @(posedge clk);
      #1;
      ed = q_d.pop_front();
      es = q_s.pop_front();
      check("sb_dflt", 32'(d_obs()), 32'(ed));
      check("sb_small", 32'(s_obs()), 32'(es));
      if (tbl_idx < 14 && n == tbl[tbl_idx].n) begin
         check($sformatf("tbl_%0d", tbl[tbl_idx].n), 32'(d_obs()), 32'(tbl[tbl_idx].exp));
         tbl_idx++;
      end
      if (track) begin
         if (n < 800) begin
            if (d_va) va_cnt++;
            if (!d_hs) hs_cnt++;
         end
         if (d_ls) begin
            if (last_ls >= 0) check("line_period", 32'(n - last_ls), 32'd800);
            last_ls = n;
         end
         if (s_fs) begin
            if (last_fs >= 0) check("small_frame_period", 32'(n - last_fs), 32'd640);
            last_fs = n;
         end
         if (n < 640 && s_vs) begin
            vs_cnt++;
            if (first_vs < 0) first_vs = n;
         end
      end
      n++;
   endtask

   initial begin
      bit found;
      // n, {hs, vs, va, x, y, ls, fs} for the default 640x480 active-low instance
      tbl[0]  = '{0,     mk(1'b1, 1'b1, 1'b1,   0,   0, 1'b1, 1'b1)};
      tbl[1]  = '{1,     mk(1'b1, 1'b1, 1'b1,   1,   0, 1'b0, 1'b0)};
      tbl[2]  = '{639,   mk(1'b1, 1'b1, 1'b1, 639,   0, 1'b0, 1'b0)};
      tbl[3]  = '{640,   mk(1'b1, 1'b1, 1'b0, 640,   0, 1'b0, 1'b0)};
      tbl[4]  = '{655,   mk(1'b1, 1'b1, 1'b0, 655,   0, 1'b0, 1'b0)};
      tbl[5]  = '{656,   mk(1'b0, 1'b1, 1'b0, 656,   0, 1'b0, 1'b0)};
      tbl[6]  = '{751,   mk(1'b0, 1'b1, 1'b0, 751,   0, 1'b0, 1'b0)};
      tbl[7]  = '{752,   mk(1'b1, 1'b1, 1'b0, 752,   0, 1'b0, 1'b0)};
      tbl[8]  = '{799,   mk(1'b1, 1'b1, 1'b0, 799,   0, 1'b0, 1'b0)};
      tbl[9]  = '{800,   mk(1'b1, 1'b1, 1'b1,   0,   1, 1'b1, 1'b0)};
      tbl[10] = '{1599,  mk(1'b1, 1'b1, 1'b0, 799,   1, 1'b0, 1'b0)};
      tbl[11] = '{1600,  mk(1'b1, 1'b1, 1'b1,   0,   2, 1'b1, 1'b0)};
      tbl[12] = '{80799, mk(1'b1, 1'b1, 1'b0, 799, 100, 1'b0, 1'b0)};
      tbl[13] = '{80800, mk(1'b1, 1'b1, 1'b1,   0, 101, 1'b1, 1'b0)};

      // power-up reset held for 5 cycles
      rst_n = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check_reset("reset_hold");
      rst_n = 1'b1;

      for (int i = 0; i <= 80801; i++) step();
      track = 1'b0;

      check("line_active_cycles", 32'(va_cnt), 32'd640);
      check("line_hsync_cycles", 32'(hs_cnt), 32'd96);
      check("small_vsync_cycles", 32'(vs_cnt), 32'(S_VS * 32));
      check("small_vsync_start", 32'(first_vs), 32'((S_VA + S_VF) * 32));
      check("tbl_all_visited", 32'(tbl_idx), 32'd14);

      // mid-frame reset: small instance at y=10, x=20 (bounded search)
      found = 1'b0;
      for (int i = 0; i < 700 && !found; i++) begin
         step();
         if (s_x == 10'd20 && s_y == 10'd10) found = 1'b1;
      end
      check("mid_point_reached", 32'(found), 32'd1);
      #5;
      rst_n = 1'b0;
      #1;
      check_reset("async_reset");
      repeat (3) @(posedge clk);
      #1;
      check_reset("reset_held3");
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      step();
      check("restart_dflt", 32'(d_obs()), 32'(mk(1'b1, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1)));
      check("restart_small", 32'(s_obs()), 32'(mk(1'b0, 1'b0, 1'b1, 0, 0, 1'b1, 1'b1)));
      // one full small frame plus its wrap back to (0,0)
      for (int i = 0; i < 660; i++) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_timing_generator.md
# vga_timing_generator

Raster timing generator for the 640x480@60 Hz VGA output. Runs in the 25 MHz pixel clock domain produced by the clock generator and is held in reset until that MMCM reports lock. It produces the horizontal and vertical counters, sync pulses, active-video flag and line/frame strobes that drive the pixel pipeline and the VGA connector.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 1'b0, asserted level of hsync (0 = active-low)
- VSYNC_POL, 1'b0, asserted level of vsync

Ports:
- clk_in  input  1  25 MHz pixel clock from the clock generator's BUFG output
- reset_n  input  1  asynchronous, active-low reset; top level drives it from the MMCM locked output, synchronised on deassertion
- hsync  output  1  horizontal sync, level set by HSYNC_POL
- vsync  output  1  vertical sync, level set by VSYNC_POL
- video_active  output  1  high while the current pixel is visible
- pixel_x  output  10  current horizontal position, 0..H_TOTAL-1
- pixel_y  output  10  current vertical position, 0..V_TOTAL-1
- line_start  output  1  one-cycle pulse when pixel_x == 0
- frame_start  output  1  one-cycle pulse when pixel_x == 0 and pixel_y == 0

## Operation
- H_TOTAL = sum of the H_* parameters (800). V_TOTAL = sum of the V_* parameters (525).
- Internal counters h_cnt and v_cnt are 10 bits wide and reset to 0.
- h_cnt increments every cycle. At H_TOTAL-1 it wraps to 0.
- v_cnt increments only on an h_cnt wrap. At V_TOTAL-1, on an h_cnt wrap, it wraps to 0. The h and v wraps occur in the same cycle at the frame end.
- All outputs are registered and are decoded from the counter values before the increment. Every output therefore describes one pixel position and all outputs stay mutually aligned.
- hsync is asserted while H_ACTIVE+H_FRONT <= x < H_ACTIVE+H_FRONT+H_SYNC, i.e. 656..751.
- vsync is asserted while V_ACTIVE+V_FRONT <= y < V_ACTIVE+V_FRONT+V_SYNC, i.e. 490..491. vsync edges coincide with x == 0.
- video_active = (x < H_ACTIVE) and (y < V_ACTIVE).
- There are no illegal states. Counters never exceed TOTAL-1; any out-of-range value wraps to 0 on the next increment.

## Timing
- Values while reset_n is low: hsync = ~HSYNC_POL, vsync = ~VSYNC_POL, video_active = 0, pixel_x = 0, pixel_y = 0, line_start = 0, frame_start = 0.
- First rising clk_in edge after reset_n deasserts: the outputs show pixel (0,0), video_active = 1, line_start = 1, frame_start = 1.
- Latency is one cycle from counter to output. From then on, one pixel is presented per clock with no gaps.
- Line period is 800 cycles. Frame period is 420000 cycles (≈59.52 Hz at 25 MHz).
- If reset_n asserts mid-frame, all outputs return to their reset values immediately (asynchronously). Restart behaves exactly as after power-up, with a fresh frame_start.
- If locked drops, reset_n falls and the block holds its reset values until lock is regained.

## Structure
- Package vga_pkg holds:
  - default timing localparams for 640x480@60
  - H_TOTAL and V_TOTAL
  - the coordinate width localparam COORD_W = 10
  - a typedef coord_t = logic [COORD_W-1:0]
- The downstream pixel generator imports the same package.
- Single module with no sub-modules. The horizontal and vertical counters are simple enough to stay inline.

## Test plan
- Reset release: hold reset_n low for 5 cycles, check all reset values, then release. First edge gives x=0, y=0, frame_start=1, video_active=1.
- Line timing: over one line, video_active is high for exactly 640 cycles. hsync is at the asserted level from x=656 through x=751 (96 cycles). line_start repeats every 800 cycles.
- Frame timing: frame_start pulses are exactly 420000 cycles apart. vsync is asserted for 1600 cycles, starting at y=490, x=0.
- Wrap boundary: at x=799, y=524, the next cycle gives x=0, y=0 with frame_start=1. At x=799, y=100, the next cycle gives x=0, y=101 with line_start=1.
- Mid-frame reset: assert reset_n at y=300, x=400 and hold for 3 cycles. Outputs drop to reset values without waiting for a clock edge. After release, the frame restarts at (0,0).
- Polarity: with HSYNC_POL=1, VSYNC_POL=1, sync outputs idle low and pulse high over the same windows.
